muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle 32-bit multiply/divide unit with architectural HI/LO.
// Multiplies by radix-2 shift-add and divides by radix-2 restoring
// shift-subtract on operand magnitudes. Each takes 32 iterations, followed by
// one FIX cycle that applies sign correction and writes HI/LO.
module muldiv_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;       // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
    logic [31:0] opnd;      // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic        neg_res;   // product / quotient must be negated
    logic        neg_rem;   // remainder must be negated (dividend sign)
    logic        is_div;
    logic        div_zero;

    logic        issue_mul, issue_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] mul_next, div_next, prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Operand decode, magnitudes and one iteration of each radix-2 step
    always_comb begin
        issue_mul = start && (op == 3'b000 || op == 3'b001);
        issue_div = start && (op == 3'b010 || op == 3'b011);
        a_neg     = ~op[0] & a[31];
        b_neg     = ~op[0] & b[31];
        a_mag     = a_neg ? (32'd0 - a) : a;
        b_mag     = b_neg ? (32'd0 - b) : b;

        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};

        div_sh    = {acc[63:32], acc[31]};
        div_diff  = div_sh - {1'b0, opnd};
        div_next  = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

        prod_fix  = neg_res ? (64'd0 - acc) : acc;
        quo_fix   = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix   = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and busy flag; flush overrides every transition
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (issue_mul)      state_next = MUL;
                else if (issue_div) state_next = DIV;
            end
            MUL, DIV: if (cnt == 5'd31) state_next = FIX;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Datapath: operand latch, iterations, FIX write-back and MTHI/MTLO
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (issue_mul) begin
                            acc     <= {32'd0, b_mag};
                            opnd    <= a_mag;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= 1'b0;
                            is_div  <= 1'b0;
                            cnt     <= '0;
                        end else if (issue_div) begin
                            acc      <= {32'd0, a_mag};
                            opnd     <= b_mag;
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            div_zero <= (b == 32'd0);
                            is_div   <= 1'b1;
                            cnt      <= '0;
                        end else if (start && op == 3'b100) begin
                            hi <= a;
                        end else if (start && op == 3'b101) begin
                            lo <= a;
                        end
                    end
                    MUL: begin
                        acc <= mul_next;
                        cnt <= cnt + 5'd1;
                    end
                    DIV: begin
                        acc <= div_next;
                        cnt <= cnt + 5'd1;
                    end
                    FIX: begin
                        // Divide by zero leaves all-ones quotient and |a| as
                        // remainder; re-signing the remainder restores a.
                        if (is_div) begin
                            lo <= div_zero ? '1 : quo_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                        done <= 1'b1;
                        cnt  <= '0;
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule
